// File: rtl/adxl345_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adxl345_pkg
//  Purpose  : Shared definitions for the ADXL345 SPI responder: register
//             addresses, command-byte bit positions, FSM state type and
//             small address-classification helpers.
//  Revision : 1.0  initial release
// ============================================================================
package adxl345_pkg;

    localparam logic [5:0] c_addr_devid       = 6'h00;
    localparam logic [5:0] c_addr_power_ctl   = 6'h2D;
    localparam logic [5:0] c_addr_int_enable  = 6'h2E;
    localparam logic [5:0] c_addr_int_source  = 6'h30;
    localparam logic [5:0] c_addr_data_format = 6'h31;
    localparam logic [5:0] c_addr_datax0      = 6'h32;
    localparam logic [5:0] c_addr_datax1      = 6'h33;
    localparam logic [5:0] c_addr_datay0      = 6'h34;
    localparam logic [5:0] c_addr_datay1      = 6'h35;
    localparam logic [5:0] c_addr_dataz0      = 6'h36;
    localparam logic [5:0] c_addr_dataz1      = 6'h37;

    // Command byte layout: {R/nW, MB, addr[5:0]}
    localparam int unsigned c_bit_rnw = 7;
    localparam int unsigned c_bit_mb  = 6;

    typedef enum logic [2:0] {
        WAIT_CS = 3'd0,
        IDLE    = 3'd1,
        CMD     = 3'd2,
        WDATA   = 3'd3,
        RDATA   = 3'd4
    } spi_rsp_state_t;

    function automatic logic is_writable(input logic [5:0] a);
        return (a == c_addr_power_ctl) || (a == c_addr_int_enable) ||
               (a == c_addr_data_format);
    endfunction

    // Reads from these addresses consume the current sample (clear data_ready)
    function automatic logic is_data_addr(input logic [5:0] a);
        return (a >= c_addr_datax0) && (a <= c_addr_dataz1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pin_sync
//  Purpose  : Two-flop synchronizer for one asynchronous pin plus single-cycle
//             rise/fall pulses derived from the synchronized level.
//  Ports    : i_clk, i_rst (sync, active-high), i_pin (async input),
//             o_level (synchronized level), o_rise / o_fall (1-cycle pulses)
//  Revision : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0   // level assumed for the pin while in reset
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/adxl345_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : adxl345_spi_responder
//  Purpose  : 3-wire SPI (mode 3) responder emulating the ADXL345 register
//             map. Pins are oversampled in the i_clk domain.
//  Ports    : i_clk/i_rst          system clock, sync active-high reset
//             i_sclk/i_cs_n/i_sdio SPI pins from the initiator
//             o_sdio/o_sdio_oe     SDIO drive value and tristate enable
//             o_int1               data-ready interrupt
//             i_x/y/z_data         axis samples, i_sample_valid pulse
//             o_wr_strobe/addr/data  report of each accepted write byte
//  Revision : 1.0  initial release
// ============================================================================
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter int         DATA_W = 10,
    parameter logic [7:0] DEVID  = 8'hE5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_sdio,
    output logic              o_sdio,
    output logic              o_sdio_oe,
    output logic              o_int1,
    input  logic [DATA_W-1:0] i_x_data,
    input  logic [DATA_W-1:0] i_y_data,
    input  logic [DATA_W-1:0] i_z_data,
    input  logic              i_sample_valid,
    output logic              o_wr_strobe,
    output logic [5:0]        o_wr_addr,
    output logic [7:0]        o_wr_data
);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_unused_cs_fall;
    logic w_sdio, w_unused_sdio_rise, w_unused_sdio_fall;

    // cs_n resets to "asserted" so a transaction already in flight when reset
    // drops is not joined: the FSM waits until the real pin is seen high.
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_unused_cs_fall));
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sdio (
        .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_sdio),
        .o_level(w_sdio), .o_rise(w_unused_sdio_rise), .o_fall(w_unused_sdio_fall));

    spi_rsp_state_t r_state, w_state_nxt;

    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift;
    logic              r_mb;
    logic [5:0]        r_addr;
    logic [7:0]        r_tx;
    logic              r_oe;
    logic              r_rd_data;
    logic [7:0]        r_power_ctl, r_int_enable, r_data_format;
    logic [DATA_W-1:0] r_x, r_y, r_z;
    logic [DATA_W-1:0] r_shd_x, r_shd_y, r_shd_z;
    logic              r_shd_pend;
    logic              r_data_ready;
    logic              w_copy;
    logic [7:0]        w_byte;
    logic [7:0]        w_rd_byte;
    logic [15:0]       w_x16, w_y16, w_z16;
    logic              w_unused_sclk_lvl;

    assign w_unused_sclk_lvl = w_sclk_lvl;
    assign w_byte  = {r_shift, w_sdio};
    // Shadow is only published while the bus is idle so a burst read never
    // mixes bytes of two samples.
    assign w_copy  = w_cs_lvl & r_shd_pend;
    assign w_x16   = {{(16-DATA_W){r_x[DATA_W-1]}}, r_x};
    assign w_y16   = {{(16-DATA_W){r_y[DATA_W-1]}}, r_y};
    assign w_z16   = {{(16-DATA_W){r_z[DATA_W-1]}}, r_z};
    // Enable drops in the very cycle the cs_n rise is detected.
    assign o_sdio_oe = r_oe & ~w_cs_rise;

    always_comb begin
        w_rd_byte = 8'h00;
        case (r_addr)
            c_addr_devid:       w_rd_byte = DEVID;
            c_addr_power_ctl:   w_rd_byte = r_power_ctl;
            c_addr_int_enable:  w_rd_byte = r_int_enable;
            c_addr_int_source:  w_rd_byte = {r_data_ready, 7'b0};
            c_addr_data_format: w_rd_byte = r_data_format;
            c_addr_datax0:      w_rd_byte = w_x16[7:0];
            c_addr_datax1:      w_rd_byte = w_x16[15:8];
            c_addr_datay0:      w_rd_byte = w_y16[7:0];
            c_addr_datay1:      w_rd_byte = w_y16[15:8];
            c_addr_dataz0:      w_rd_byte = w_z16[7:0];
            c_addr_dataz1:      w_rd_byte = w_z16[15:8];
            default:            w_rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_CS: if (w_cs_lvl)  w_state_nxt = IDLE;
            IDLE:    if (!w_cs_lvl) w_state_nxt = CMD;
            CMD:     if (w_sclk_rise && (r_bit_cnt == 3'd7))
                         w_state_nxt = w_byte[c_bit_rnw] ? RDATA : WDATA;
            default: w_state_nxt = r_state;
        endcase
        if (w_cs_rise) w_state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= WAIT_CS;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_mb          <= 1'b0;
            r_addr        <= '0;
            r_tx          <= '0;
            r_oe          <= 1'b0;
            r_rd_data     <= 1'b0;
            o_sdio        <= 1'b0;
            o_int1        <= 1'b0;
            o_wr_strobe   <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            r_power_ctl   <= '0;
            r_int_enable  <= '0;
            r_data_format <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_z           <= '0;
            r_shd_x       <= '0;
            r_shd_y       <= '0;
            r_shd_z       <= '0;
            r_shd_pend    <= 1'b0;
            r_data_ready  <= 1'b0;
        end else begin
            o_wr_strobe <= 1'b0;

            if (i_sample_valid) begin
                r_shd_x    <= i_x_data;
                r_shd_y    <= i_y_data;
                r_shd_z    <= i_z_data;
                r_shd_pend <= 1'b1;
            end else if (w_copy) begin
                r_shd_pend <= 1'b0;
            end
            if (w_copy) begin
                r_x <= r_shd_x;
                r_y <= r_shd_y;
                r_z <= r_shd_z;
            end

            // A fresh sample outranks the clear from a concluding data read.
            if (w_copy && r_power_ctl[3])     r_data_ready <= 1'b1;
            else if (w_cs_rise && r_rd_data)  r_data_ready <= 1'b0;
            o_int1 <= r_data_ready & r_int_enable[7];

            case (r_state)
                IDLE: r_bit_cnt <= '0;
                CMD: if (w_sclk_rise) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_shift   <= w_byte[6:0];
                    if (r_bit_cnt == 3'd7) begin
                        r_mb   <= w_byte[c_bit_mb];
                        r_addr <= w_byte[5:0];
                    end
                end
                WDATA: if (w_sclk_rise) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_shift   <= w_byte[6:0];
                    if (r_bit_cnt == 3'd7) begin
                        o_wr_strobe <= 1'b1;
                        o_wr_addr   <= r_addr;
                        o_wr_data   <= w_byte;
                        if (r_addr == c_addr_power_ctl)   r_power_ctl   <= w_byte;
                        if (r_addr == c_addr_int_enable)  r_int_enable  <= w_byte;
                        if (r_addr == c_addr_data_format) r_data_format <= w_byte;
                        if (r_mb) r_addr <= r_addr + 6'd1;
                    end
                end
                RDATA: if (w_sclk_fall) begin
                    r_oe      <= 1'b1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd0) begin
                        // Byte boundary: fetch, then advance for the next byte.
                        o_sdio <= w_rd_byte[7];
                        r_tx   <= {w_rd_byte[6:0], 1'b0};
                        if (is_data_addr(r_addr)) r_rd_data <= 1'b1;
                        if (r_mb) r_addr <= r_addr + 6'd1;
                    end else begin
                        o_sdio <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                end
                default: ;
            endcase

            if (w_cs_rise) begin
                r_bit_cnt <= '0;
                r_oe      <= 1'b0;
                r_rd_data <= 1'b0;
                o_sdio    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
